// File: rtl/tea_cipher_core_if.sv
// Request/response bundle for the TEA cipher engine.
// The master drives the request side; the slave returns the result.
interface tea_cipher_core_if;
   logic         ena;
   logic         start;
   logic         mode;
   logic [63:0]  data;
   logic [127:0] key;
   logic [63:0]  expected;
   logic [63:0]  result;
   logic         valid;
   logic         match;
   logic         rdy;

   modport master (
      output ena, start, mode, data, key, expected,
      input  result, valid, match, rdy
   );

   modport slave (
      input  ena, start, mode, data, key, expected,
      output result, valid, match, rdy
   );
endinterface

// File: rtl/tea_cipher_core.sv
// Iterative TEA encrypt/decrypt engine, one full TEA cycle per enabled clock.
// Compares each finished block against a reference latched at start.
module tea_cipher_core #(
   parameter int unsigned ROUNDS = 32,
   parameter logic [31:0] DELTA  = 32'h9E3779B9
) (
   input logic             clk,
   input logic             rst,
   tea_cipher_core_if.slave bus
);

   localparam int unsigned    CW      = $clog2(ROUNDS + 1);
   localparam logic [CW-1:0]  LAST    = CW'(ROUNDS - 1);
   localparam logic [31:0]    SUM_DEC = 32'(DELTA * ROUNDS);

   typedef enum logic {IDLE, RUN} state_t;

   state_t         state;
   logic [CW-1:0]  cnt;
   logic [31:0]    sum;
   logic [31:0]    v0;
   logic [31:0]    v1;
   logic [127:0]   key_q;
   logic [63:0]    exp_q;
   logic           mode_q;
   logic [63:0]    result_q;
   logic           valid_q;
   logic           match_q;
   logic           rdy_q;

   logic [31:0]    k0, k1, k2, k3;
   logic [31:0]    sum_n;
   logic [31:0]    v0_n;
   logic [31:0]    v1_n;

   function automatic logic [31:0] mix(
      input logic [31:0] v,
      input logic [31:0] ka,
      input logic [31:0] kb,
      input logic [31:0] s
   );
      return ((v << 4) + ka) ^ (v + s) ^ ((v >> 5) + kb);
   endfunction

   assign k0 = key_q[127:96];
   assign k1 = key_q[95:64];
   assign k2 = key_q[63:32];
   assign k3 = key_q[31:0];

   // One TEA cycle: encrypt runs v0 then v1, decrypt undoes it in reverse.
   always_comb begin
      sum_n = sum;
      v0_n  = v0;
      v1_n  = v1;
      if (!mode_q) begin
         sum_n = sum + DELTA;
         v0_n  = v0 + mix(v1, k0, k1, sum_n);
         v1_n  = v1 + mix(v0_n, k2, k3, sum_n);
      end else begin
         v1_n  = v1 - mix(v0, k2, k3, sum);
         v0_n  = v0 - mix(v1_n, k0, k1, sum);
         sum_n = sum - DELTA;
      end
   end

   // Control FSM plus round datapath; valid is a one-clock pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         cnt      <= '0;
         sum      <= '0;
         v0       <= '0;
         v1       <= '0;
         key_q    <= '0;
         exp_q    <= '0;
         mode_q   <= 1'b0;
         result_q <= '0;
         valid_q  <= 1'b0;
         match_q  <= 1'b0;
         rdy_q    <= 1'b1;
      end else begin
         valid_q <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.start && bus.ena) begin
                  v0     <= bus.data[63:32];
                  v1     <= bus.data[31:0];
                  key_q  <= bus.key;
                  exp_q  <= bus.expected;
                  mode_q <= bus.mode;
                  sum    <= bus.mode ? SUM_DEC : 32'h0;
                  cnt    <= '0;
                  rdy_q  <= 1'b0;
                  state  <= RUN;
               end
            end
            RUN: begin
               if (bus.ena) begin
                  sum <= sum_n;
                  v0  <= v0_n;
                  v1  <= v1_n;
                  cnt <= cnt + CW'(1);
                  if (cnt == LAST) begin
                     result_q <= {v0_n, v1_n};
                     match_q  <= ({v0_n, v1_n} == exp_q);
                     valid_q  <= 1'b1;
                     rdy_q    <= 1'b1;
                     state    <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.result = result_q;
   assign bus.valid  = valid_q;
   assign bus.match  = match_q;
   assign bus.rdy    = rdy_q;

endmodule

// File: tb/tb_tea_cipher_core.sv
// Scoreboard bench for tea_cipher_core at the default 32 rounds.
// Stimulus pushes expectations; a negedge monitor pops them on valid.
module tb_tea_cipher_core;

   localparam logic [31:0] DELTA = 32'h9E3779B9;
   localparam int          NR    = 32;

   typedef struct {
      logic [63:0] result;
      logic        match;
      int          acc;
      int          lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;
   int   n_assert = 0;
   int   n_fail = 0;
   logic prev_valid = 1'b0;
   exp_t sb[$];

   tea_cipher_core_if bus();

   tea_cipher_core dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [63:0] tea_model(
      input logic         md,
      input logic [63:0]  d,
      input logic [127:0] k,
      input int           r
   );
      logic [31:0] a, b, s, k0, k1, k2, k3;
      a  = d[63:32];
      b  = d[31:0];
      k0 = k[127:96];
      k1 = k[95:64];
      k2 = k[63:32];
      k3 = k[31:0];
      if (!md) begin
         s = 32'h0;
         for (int i = 0; i < r; i++) begin
            s = s + DELTA;
            a = a + (((b << 4) + k0) ^ (b + s) ^ ((b >> 5) + k1));
            b = b + (((a << 4) + k2) ^ (a + s) ^ ((a >> 5) + k3));
         end
      end else begin
         s = 32'(DELTA * 32'(r));
         for (int i = 0; i < r; i++) begin
            b = b - (((a << 4) + k2) ^ (a + s) ^ ((a >> 5) + k3));
            a = a - (((b << 4) + k0) ^ (b + s) ^ ((b >> 5) + k1));
            s = s - DELTA;
         end
      end
      return {a, b};
   endfunction

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] req);
      n_assert++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", name, act, req);
      end
   endtask

   // Issue one request; the expected response goes into the scoreboard.
   task automatic issue(input logic md, input logic [63:0] d,
                        input logic [127:0] k, input logic [63:0] e,
                        input logic [63:0] want, input int lat,
                        input bit hold);
      int n;
      exp_t x;
      n = 0;
      while (!bus.rdy && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (!bus.rdy) begin
         n_assert++;
         n_fail++;
         $display("FAIL rdy_wait: got rdy=0, want 1 within 500 cycles");
      end
      bus.ena      = 1'b1;
      bus.start    = 1'b1;
      bus.mode     = md;
      bus.data     = d;
      bus.key      = k;
      bus.expected = e;
      @(negedge clk);
      x.result = want;
      x.match  = (want == e);
      x.acc    = cyc;
      x.lat    = lat;
      sb.push_back(x);
      if (!hold) bus.start = 1'b0;
   endtask

   // Monitor: every valid must correspond to a queued expectation.
   always @(negedge clk) begin
      exp_t x;
      if (rst && bus.valid) begin
         check("valid_single", {63'h0, prev_valid}, 64'h0);
         if (sb.size() == 0) begin
            n_assert++;
            n_fail++;
            $display("FAIL spurious_valid: got valid=1, want 0 (no request pending)");
         end else begin
            x = sb.pop_front();
            check("result", bus.result, x.result);
            check("match", {63'h0, bus.match}, {63'h0, x.match});
            check("latency", 64'(cyc - x.acc), 64'(x.lat));
         end
      end
      prev_valid = bus.valid;
   end

   logic [63:0]  vd [4];
   logic [127:0] vk [4];
   logic [63:0]  ct;

   initial begin
      int n;
      vd[0] = 64'h0123_4567_89AB_CDEF;  vk[0] = 128'h0;
      vd[1] = 64'hFFFF_FFFF_FFFF_FFFF;  vk[1] = {128{1'b1}};
      vd[2] = 64'h0000_0001_0000_0000;  vk[2] = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
      vd[3] = 64'hDEAD_BEEF_CAFE_F00D;   vk[3] = 128'h0000_0001_0000_0002_0000_0003_0000_0004;

      bus.ena = 1'b1;
      bus.start = 1'b0;
      bus.mode = 1'b0;
      bus.data = '0;
      bus.key = '0;
      bus.expected = '0;

      repeat (3) @(negedge clk);
      check("reset_rdy", {63'h0, bus.rdy}, 64'h1);
      check("reset_valid", {63'h0, bus.valid}, 64'h0);
      check("reset_match", {63'h0, bus.match}, 64'h0);
      check("reset_result", bus.result, 64'h0);
      rst = 1'b1;

      issue(1'b0, 64'h0, 128'h0, 64'h41EA3A0A_94BAA940,
            64'h41EA3A0A_94BAA940, NR, 1'b0);
      issue(1'b1, 64'h41EA3A0A_94BAA940, 128'h0, 64'h1,
            64'h0, NR, 1'b0);

      for (int i = 0; i < 4; i++) begin
         ct = tea_model(1'b0, vd[i], vk[i], NR);
         issue(1'b0, vd[i], vk[i], ct, ct, NR, 1'b0);
         issue(1'b1, ct, vk[i], vd[i], vd[i], NR, 1'b0);
      end

      ct = tea_model(1'b0, vd[3], vk[3], NR);
      issue(1'b0, vd[3], vk[3], ct, ct, 2 * NR, 1'b0);
      for (int i = 0; i < 2 * NR; i++) begin
         bus.ena = i[0];
         if (i == 10) begin
            bus.start = 1'b1;
            bus.data  = 64'h1111_2222_3333_4444;
            bus.mode  = 1'b1;
         end
         if (i == 12) begin
            bus.start = 1'b0;
            check("busy_rdy", {63'h0, bus.rdy}, 64'h0);
         end
         @(negedge clk);
      end
      bus.ena = 1'b1;

      for (int i = 0; i < 3; i++) begin
         ct = tea_model(1'b0, vd[i], vk[i], NR);
         issue(1'b0, vd[i], vk[i], ct, ct, NR, 1'b1);
      end
      bus.start = 1'b0;

      issue(1'b0, vd[2], vk[2], 64'h0, tea_model(1'b0, vd[2], vk[2], NR),
            NR, 1'b0);
      repeat (10) @(negedge clk);
      rst = 1'b0;
      sb.delete();
      #1;
      check("abort_rdy", {63'h0, bus.rdy}, 64'h1);
      check("abort_valid", {63'h0, bus.valid}, 64'h0);
      check("abort_result", bus.result, 64'h0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      ct = tea_model(1'b0, vd[1], vk[1], NR);
      issue(1'b0, vd[1], vk[1], ct, ct, NR, 1'b0);

      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         n_assert++;
         n_fail++;
         $display("FAIL drain: got %0d pending, want 0", sb.size());
      end
      repeat (40) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/tea_cipher_core.md
# tea_cipher_core

Parametrised, iterative TEA cipher engine that encrypts or decrypts one 64-bit block per request under a 128-bit key. It performs one full TEA cycle (two Feistel half-rounds) per enabled clock. It adds runtime mode selection, a configurable round count and an on-chip comparison against an expected value. It sits behind the request/response front end of the decoder datapath, where it replaces the fixed-function validity checker.

## Interface
- ROUNDS, 32: number of TEA cycles per block; legal range 1..255.
- DELTA, 32'h9E3779B9: key-schedule constant.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-low (asserted at 0).
- ena  in  1  clock enable; while low, the FSM, counter and datapath hold.
- start  in  1  request strobe; accepted only when rdy=1 and ena=1.
- mode  in  1  0 = encrypt, 1 = decrypt; sampled with start.
- data  in  64  input block; v0=data[63:32], v1=data[31:0].
- key  in  128  k0=key[127:96], k1=key[95:64], k2=key[63:32], k3=key[31:0].
- expected  in  64  reference block; sampled with start.
- result  out  64  output block {v0,v1}; held until the next completion.
- valid  out  1  one-cycle pulse marking completion; result and match are valid while it is high and remain stable after.
- match  out  1  registered (result == expected), updated with valid.
- rdy  out  1  high when a new start can be accepted.

## Operation
- States: IDLE, RUN.
- IDLE: rdy=1. On start&ena, the block:
  - latches data, key, mode and expected;
  - sets sum to 0 for encrypt, or to (DELTA*ROUNDS) mod 2^32 for decrypt (0xC6EF3720 at defaults);
  - sets the round counter to 0 and goes to RUN with rdy=0.
- RUN: each ena=1 cycle performs one TEA cycle, and the counter increments.
- Encrypt cycle, with all arithmetic mod 2^32 and logical shifts:
  - sum+=DELTA;
  - v0+=((v1<<4)+k0)^(v1+sum)^((v1>>5)+k1);
  - v1+=((v0'<<4)+k2)^(v0'+sum)^((v0'>>5)+k3), where v0' is the updated v0.
- Decrypt cycle is the exact inverse:
  - v1-=f(v0,k2,k3,sum);
  - v0-=f(v1',k0,k1,sum);
  - sum-=DELTA.
- On the cycle that completes round ROUNDS-1:
  - result<={v0,v1}, match<=({v0,v1}==expected_latched), valid<=1;
  - state goes to IDLE and rdy<=1.
- A start while rdy=0 is ignored. Input changes after acceptance have no effect.
- A start with ena=0 is not accepted.
- Reset values: state IDLE, rdy=1, valid=0, match=0, result=0, counter=0, sum=0, internal v0/v1 and latched key/expected all 0.
- Reset asserted mid-RUN aborts the operation immediately (asynchronously). No valid is produced for the aborted block.

## Timing
- Acceptance at rising edge N. Rounds execute at edges N+1..N+ROUNDS if ena stays high.
- valid=1 and rdy=1 in the cycle following edge N+ROUNDS, so latency is ROUNDS cycles.
- Each ena=0 cycle during RUN adds one cycle of latency. The counter and sum freeze.
- valid lasts exactly one clock and deasserts regardless of ena.
- Back-to-back operation: start high in the valid cycle is accepted at the next edge. Throughput is one block per ROUNDS+1 cycles.
- The counter is $clog2(ROUNDS+1) bits wide. It never wraps, because RUN exits at ROUNDS.
- rst deassertion is synchronised externally. The first edge after release may accept start.

## Test plan
- Reset, then encrypt with key=0, data=0, ROUNDS=32 -> after 32 cycles valid=1 and result=64'h41EA3A0A_94BAA940. With expected set to the same value, match=1.
- Decrypt with key=0, data=64'h41EA3A0A_94BAA940 -> result=0 after 32 cycles. With expected=1, match=0.
- Randomised key/data: encrypt, feed result back with mode=1 -> the original data is recovered and match=1, for 1000 vectors. Also run at ROUNDS=1 and ROUNDS=64.
- ena toggled 0/1 every other cycle during RUN -> valid arrives at cycle 64 (2×ROUNDS) and result is identical to the ena=1 run. A start pulsed while busy is ignored and rdy stays 0.
- Back-to-back: start held high continuously -> valid pulses every 33 cycles, and each result matches its own input.
- rst pulled low at round 10, released, then a new encrypt -> during reset rdy=1, valid=0, result=0. The new block completes correctly after 32 cycles, with no spurious valid from the aborted block.
